// File: rtl/ram32_arbiter.sv
// ---------------------------------------------------------------------------
// ram32_arbiter
//   Two-port round-robin access controller in front of one RAM32
//   (32 x 16-bit, latch-based). Each master holds a request until it is
//   granted; the arbiter then owns the RAM for one ACCESS cycle and returns
//   a one-cycle ack (with read data for reads) on the owning port.
//
//   Optional build macro: RAM32_ARB_INIT_EN
//     When defined, reset enters an INIT sweep that writes zero to every
//     word (one per cycle, DEPTH cycles) before any request is granted.
//
// Ports
//   i_clk, i_reset        clock, synchronous active-high reset
//   i_req0/1              port request, held with we/addr/wdata until gnt
//   i_we0/1               1 = write, 0 = read
//   i_addr0/1, i_wdata0/1 port address and write data
//   o_gnt0/1              combinational grant, accepted at this rising edge
//   o_ack0/1              registered one-cycle completion pulse
//   o_rdata0/1            read data, valid while ack is high after a read
//   o_ramAddr/o_ramIn     RAM32 address and write data
//   o_ramWrite            RAM32 write strobe
//   i_ramOut              RAM32 read data
//   o_busy                high in ACCESS (and INIT)
// ---------------------------------------------------------------------------
module ram32_arbiter #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 32
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_req0,
  input  logic              i_we0,
  input  logic [ADDR_W-1:0] i_addr0,
  input  logic [DATA_W-1:0] i_wdata0,
  output logic              o_gnt0,
  output logic              o_ack0,
  output logic [DATA_W-1:0] o_rdata0,
  input  logic              i_req1,
  input  logic              i_we1,
  input  logic [ADDR_W-1:0] i_addr1,
  input  logic [DATA_W-1:0] i_wdata1,
  output logic              o_gnt1,
  output logic              o_ack1,
  output logic [DATA_W-1:0] o_rdata1,
  output logic [ADDR_W-1:0] o_ramAddr,
  output logic [DATA_W-1:0] o_ramIn,
  output logic              o_ramWrite,
  input  logic [DATA_W-1:0] i_ramOut,
  output logic              o_busy
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
`ifdef RAM32_ARB_INIT_EN
  localparam logic [1:0] ST_INIT   = 2'd2;
  localparam logic [1:0] ST_RESET  = ST_INIT;
`else
  localparam logic [1:0] ST_RESET  = ST_IDLE;
`endif

  logic [1:0]        r_state;
  logic              r_lastGrant;
  logic [ADDR_W-1:0] r_ramAddr;
  logic [DATA_W-1:0] r_ramIn;
  logic              r_opWe;
  logic              r_opPort;
  logic              r_ack0;
  logic              r_ack1;
  logic [DATA_W-1:0] r_rdata0;
  logic [DATA_W-1:0] r_rdata1;
`ifdef RAM32_ARB_INIT_EN
  logic [ADDR_W-1:0] r_initCnt;
`endif

  logic w_idle;
  logic w_gnt0;
  logic w_gnt1;
  logic w_initActive;

  // Round robin: a lone requester always wins; on a tie the port that was
  // not granted last time wins. Grants are suppressed during reset and
  // outside IDLE, so the two grants can never be high together.
  assign w_idle = (r_state == ST_IDLE) && !i_reset;
  assign w_gnt0 = w_idle && i_req0 && (!i_req1 || r_lastGrant);
  assign w_gnt1 = w_idle && i_req1 && (!i_req0 || !r_lastGrant);

`ifdef RAM32_ARB_INIT_EN
  assign w_initActive = (r_state == ST_INIT);
`else
  assign w_initActive = 1'b0;
`endif

  // The write strobe is only asserted while this block owns the RAM; gating
  // with reset keeps the strobe low the cycle after a reset lands mid-access.
  assign o_ramWrite = !i_reset && (((r_state == ST_ACCESS) && r_opWe) || w_initActive);

`ifdef RAM32_ARB_INIT_EN
  assign o_ramAddr = w_initActive ? r_initCnt : r_ramAddr;
  assign o_ramIn   = w_initActive ? '0 : r_ramIn;
`else
  assign o_ramAddr = r_ramAddr;
  assign o_ramIn   = r_ramIn;
`endif

  assign o_gnt0   = w_gnt0;
  assign o_gnt1   = w_gnt1;
  assign o_ack0   = r_ack0;
  assign o_ack1   = r_ack1;
  assign o_rdata0 = r_rdata0;
  assign o_rdata1 = r_rdata1;
  assign o_busy   = (r_state != ST_IDLE);

  // Main sequencer: IDLE latches the winning request, ACCESS lasts exactly
  // one cycle and hands the result back to the owning port, INIT (optional)
  // sweeps the whole RAM with zeros. Acks default low so they pulse.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= ST_RESET;
      r_lastGrant <= 1'b1;
      r_ramAddr   <= '0;
      r_ramIn     <= '0;
      r_opWe      <= 1'b0;
      r_opPort    <= 1'b0;
      r_ack0      <= 1'b0;
      r_ack1      <= 1'b0;
      r_rdata0    <= '0;
      r_rdata1    <= '0;
`ifdef RAM32_ARB_INIT_EN
      r_initCnt   <= '0;
`endif
    end else begin
      r_ack0 <= 1'b0;
      r_ack1 <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_gnt0 || w_gnt1) begin
            r_ramAddr   <= w_gnt1 ? i_addr1  : i_addr0;
            r_ramIn     <= w_gnt1 ? i_wdata1 : i_wdata0;
            r_opWe      <= w_gnt1 ? i_we1    : i_we0;
            r_opPort    <= w_gnt1;
            r_lastGrant <= w_gnt1;
            r_state     <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          if (r_opPort) begin
            r_ack1 <= 1'b1;
            if (!r_opWe) begin
              r_rdata1 <= i_ramOut;
            end
          end else begin
            r_ack0 <= 1'b1;
            if (!r_opWe) begin
              r_rdata0 <= i_ramOut;
            end
          end
          r_state <= ST_IDLE;
        end
`ifdef RAM32_ARB_INIT_EN
        ST_INIT: begin
          r_initCnt <= r_initCnt + 1'b1;
          if (r_initCnt == ADDR_W'(DEPTH - 1)) begin
            r_state <= ST_IDLE;
          end
        end
`endif
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
